// File: rtl/bin_to_led7_seq_if.sv
// bin_to_led7_seq_if: start/busy/done handshake and display outputs of the 7-segment driver
interface bin_to_led7_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  lz_blank;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   hex;
  modport master (output start, bin, lz_blank, input busy, done, ovf, bcd, hex);
  modport slave  (input start, bin, lz_blank, output busy, done, ovf, bcd, hex);
endinterface

// File: rtl/bin_to_led7_seq.sv
// bin_to_led7_seq: iterative double-dabble binary to BCD converter driving active-low 7-segment patterns
module bin_to_led7_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input logic              clk,
  input logic              rst,
  bin_to_led7_seq_if.slave io
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  state_t              state, state_n;
  logic [BW-1:0]       bcd_reg, bcd_adj;
  logic [BIN_W-1:0]    bin_reg;
  logic [CW-1:0]       cnt;
  logic                lz_reg, ovf_acc, lead;
  logic [BW+BIN_W-1:0] shifted;
  logic [7*DIGITS-1:0] hex_n;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  assign io.busy = state != IDLE;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state: one SHIFT cycle per input bit, then a single LOAD cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (io.start) state_n = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  // one double-dabble step: add 3 to digits >= 5, then shift the combined register left
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i+:4] = bcd_reg[4*i+:4] >= 4'd5 ? bcd_reg[4*i+:4] + 4'd3 : bcd_reg[4*i+:4];
    shifted = {bcd_adj, bin_reg} << 1;
  end

  // segment patterns: dashes on overflow, otherwise blank leading zeros above the top nonzero digit
  always_comb begin
    hex_n = '0;
    lead  = lz_reg;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead = lead && bcd_reg[4*i+:4] == 4'd0 && i != 0;
      hex_n[7*i+:7] = ovf_acc ? 7'h3F : lead ? 7'h7F : seg(bcd_reg[4*i+:4]);
    end
  end

  // conversion datapath and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      lz_reg  <= 1'b0;
      ovf_acc <= 1'b0;
      io.done <= 1'b0;
      io.ovf  <= 1'b0;
      io.bcd  <= '0;
      io.hex  <= {DIGITS{7'h7F}};
    end else begin
      io.done <= state == LOAD;
      if (state == IDLE && io.start) begin
        bin_reg <= io.bin;
        lz_reg  <= io.lz_blank;
        bcd_reg <= '0;
        ovf_acc <= 1'b0;
        cnt     <= CW'(BIN_W);
      end
      if (state == SHIFT) begin
        {bcd_reg, bin_reg} <= shifted;
        cnt                <= cnt - CW'(1);
        ovf_acc            <= ovf_acc | bcd_adj[BW-1];
      end
      if (state == LOAD) begin
        io.bcd <= bcd_reg;
        io.hex <= hex_n;
        io.ovf <= ovf_acc;
      end
    end
  end
endmodule

// File: tb/tb_bin_to_led7_seq.sv
// tb_bin_to_led7_seq: scoreboard bench for the sequential 7-segment driver at 5 and 4 digits
module tb_bin_to_led7_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin_to_led7_seq_if #(.BIN_W(16), .DIGITS(5)) a ();
  bin_to_led7_seq_if #(.BIN_W(16), .DIGITS(4)) b ();
  bin_to_led7_seq #(.BIN_W(16), .DIGITS(5)) u5 (.clk(clk), .rst(rst), .io(a));
  bin_to_led7_seq #(.BIN_W(16), .DIGITS(4)) u4 (.clk(clk), .rst(rst), .io(b));

  typedef struct packed {
    logic [19:0] bcd;
    logic [34:0] hex;
    logic        ovf;
  } exp_t;

  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  exp_t q5[$];
  exp_t q4[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat, bsy, seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int v, input bit lz, input int d);
    exp_t e;
    int   pw = 1;
    int   msd = 0;
    int   dig [5];
    e = '0;
    for (int i = 0; i < 5; i++) dig[i] = 0;
    for (int i = 0; i < d; i++) begin
      dig[i] = (v / pw) % 10;
      pw *= 10;
    end
    e.ovf = v >= pw;
    for (int i = 0; i < d; i++) begin
      e.bcd[4*i+:4] = 4'(dig[i]);
      if (dig[i] != 0) msd = i;
    end
    for (int i = 0; i < d; i++)
      e.hex[7*i+:7] = e.ovf ? 7'h3F : (lz && i > msd) ? 7'h7F : SEG[dig[i]];
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (a.done) begin
      if (q5.size() == 0) check("done5_unexpected", a.done, 0);
      else begin
        e = q5.pop_front();
        check("bcd5", a.bcd, e.bcd);
        check("hex5", a.hex, e.hex);
        check("ovf5", a.ovf, e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b.done) begin
      if (q4.size() == 0) check("done4_unexpected", b.done, 0);
      else begin
        e = q4.pop_front();
        check("bcd4", b.bcd, e.bcd);
        check("hex4", b.hex, e.hex);
        check("ovf4", b.ovf, e.ovf);
      end
    end
  end

  task automatic go5(input int v, input bit lz);
    a.start = 1'b1;
    a.bin = 16'(v);
    a.lz_blank = lz;
    q5.push_back(model(v, lz, 5));
    @(negedge clk);
    a.start = 1'b0;
  endtask

  task automatic wait5(output int l, output int bz);
    l = 0;
    bz = 0;
    while (!a.done && l < 40) begin
      if (a.busy) bz++;
      @(negedge clk);
      l++;
    end
    check("done5_timeout", a.done, 1);
  endtask

  task automatic go4(input int v, input bit lz);
    int l = 0;
    b.start = 1'b1;
    b.bin = 16'(v);
    b.lz_blank = lz;
    q4.push_back(model(v, lz, 4));
    @(negedge clk);
    b.start = 1'b0;
    while (!b.done && l < 40) begin
      @(negedge clk);
      l++;
    end
    check("done4_timeout", b.done, 1);
  endtask

  initial begin
    a.start = 1'b0; a.bin = '0; a.lz_blank = 1'b0;
    b.start = 1'b0; b.bin = '0; b.lz_blank = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", a.busy, 0);
    check("rst_done", a.done, 0);
    check("rst_ovf", a.ovf, 0);
    check("rst_bcd", a.bcd, 0);
    check("rst_hex5", a.hex, {5{7'h7F}});
    check("rst_hex4", b.hex, {4{7'h7F}});
    rst = 1'b0;
    @(negedge clk);

    go5(16'hFFFF, 1'b0);
    wait5(lat, bsy);
    check("latency", lat, 17);
    check("busy_cycles", bsy, 17);
    check("busy_at_done", a.busy, 0);
    check("bcd_ffff", a.bcd, 20'h65535);
    check("hex_ffff", a.hex, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});
    @(negedge clk);
    check("done_one_cycle", a.done, 0);
    check("bcd_hold", a.bcd, 20'h65535);

    go5(0, 1'b1);
    wait5(lat, bsy);
    check("hex_zero_lz", a.hex, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    @(negedge clk);
    go5(1234, 1'b0);
    wait5(lat, bsy);
    check("hex_1234_d4", a.hex[34:28], 7'h40);
    @(negedge clk);
    go5(1234, 1'b1);
    wait5(lat, bsy);
    check("hex_1234_lz", a.hex, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
    @(negedge clk);
    foreach (SEG[i]) begin
      go5(i * 1001 + 50000 * (i % 2), i % 3 == 0);
      wait5(lat, bsy);
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      go5(int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
      wait5(lat, bsy);
      @(negedge clk);
    end

    go5(1234, 1'b0);
    repeat (5) @(negedge clk);
    a.start = 1'b1;
    a.bin = 16'd999;
    @(negedge clk);
    a.start = 1'b0;
    wait5(lat, bsy);
    check("bcd_ignored_start", a.bcd, 20'h01234);
    repeat (20) @(negedge clk);

    a.start = 1'b1;
    a.bin = 16'd500;
    a.lz_blank = 1'b0;
    q5.push_back(model(500, 1'b0, 5));
    lat = 0;
    while (!a.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_first_timeout", a.done, 1);
    a.bin = 16'd77;
    q5.push_back(model(77, 1'b0, 5));
    @(negedge clk);
    a.start = 1'b0;
    check("b2b_no_gap", a.busy, 1);
    wait5(lat, bsy);
    check("b2b_latency", lat, 17);
    check("bcd_77", a.bcd, 20'h00077);
    @(negedge clk);

    go5(5000, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    q5.delete();
    check("abort_busy", a.busy, 0);
    check("abort_done", a.done, 0);
    check("abort_ovf", a.ovf, 0);
    check("abort_bcd", a.bcd, 0);
    check("abort_hex", a.hex, {5{7'h7F}});
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (a.done) seen++;
    end
    check("abort_no_done", seen, 0);
    go5(42, 1'b0);
    wait5(lat, bsy);
    check("bcd_42", a.bcd, 20'h00042);
    @(negedge clk);

    go4(12345, 1'b0);
    check("ovf_12345", b.ovf, 1);
    check("hex_12345", b.hex, {4{7'h3F}});
    check("bcd_12345", b.bcd, 16'h2345);
    @(negedge clk);
    check("ovf_held", b.ovf, 1);
    go4(10005, 1'b1);
    check("hex_10005_lz", b.hex, {4{7'h3F}});
    @(negedge clk);
    go4(99, 1'b0);
    check("ovf_cleared", b.ovf, 0);
    @(negedge clk);
    go4(9999, 1'b1);
    @(negedge clk);

    check("q5_drained", q5.size(), 0);
    check("q4_drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
